fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//   Shares the single framebuffer write port (gpu_clk domain) between NUM_REQ pixel-write requesters.
//   Requesters are display processor, blitter and host path; arbitration is round-robin.
//   Contains a built-in clear engine that sweeps every pixel with one palette index.
//   Sits between the requesters and the Framebuffer wr_* inputs; one write per cycle maximum.
// PARAMETERS
//   RESOLUTION_X    400   framebuffer width in pixels; XW = $clog2(RESOLUTION_X)
//   RESOLUTION_Y    300   framebuffer height in pixels; YW = $clog2(RESOLUTION_Y)
//   PALETTE_LENGTH  256   palette entries; IW = $clog2(PALETTE_LENGTH)
//   NUM_REQ         3     number of requesters (>=1)
// PORTS
//   clk          in   1           gpu_clk; all logic on rising edge
//   resetn       in   1           reset, asynchronous assert, active-low
//   req_valid    in   NUM_REQ     per-requester write request
//   req_ready    out  NUM_REQ     per-requester grant; transfer when valid&ready
//   req_x        in   NUM_REQ*XW  packed x; requester i at [i*XW +: XW]
//   req_y        in   NUM_REQ*YW  packed y
//   req_index    in   NUM_REQ*IW  packed palette index
//   clear_start  in   1           pulse: begin full-frame clear
//   clear_index  in   IW          fill index; sampled with clear_start
//   clear_busy   out  1           high while clear engine in CLEAR
//   clear_done   out  1           one-cycle pulse at clear completion
//   fb_wr_x      out  XW          to Framebuffer wr_pxl_x
//   fb_wr_y      out  YW          to Framebuffer wr_pxl_y
//   fb_wr_index  out  IW          to Framebuffer wr_palette_index
//   fb_wr_en     out  1           to Framebuffer we
//   drop_count   out  16          dropped out-of-range writes (see CONFIGURATION)
// BEHAVIOUR
//   Reset (resetn=0): all outputs 0, rr pointer=0, FSM=IDLE, clear counters=0; effective immediately.
//   Round-robin arbitration:
//   - search starts at ptr, wraps modulo NUM_REQ; first valid requester gets one-hot req_ready.
//   - req_ready is combinational from req_valid, ptr and FSM state; never asserted without valid.
//   - on a transfer from requester g, ptr <= (g+1) mod NUM_REQ; no transfer -> ptr holds.
//   Write path: fb_wr_* registered; transfer at edge k -> fb_wr_en=1 with its data after edge k.
//   - latency 1, throughput 1 write/cycle; fb_wr_en=0 on cycles with no write, fb_wr_* hold last value.
//   Clear FSM states IDLE -> CLEAR -> DONE -> IDLE:
//   - IDLE: clear_start=1 -> CLEAR; latch clear_index; cx=cy=0. Arbitration runs normally in the start cycle.
//   - CLEAR: req_ready all 0; clear_busy=1; issue write (cx,cy,latched index) every cycle.
//     cx==RESOLUTION_X-1 -> cx=0, cy++; at (RESOLUTION_X-1, RESOLUTION_Y-1) -> DONE.
//   - DONE: clear_done=1 for exactly one cycle (coincides with last clear fb_wr_en); arbitration resumes; -> IDLE.
//   - clear_start while in CLEAR or DONE: ignored, no queuing.
//   - Clear duration: exactly RESOLUTION_X*RESOLUTION_Y writes, no gaps.
//   - resetn during CLEAR: clear aborts; no clear_done; partial frame remains.
//   Requester stability: a requester holds its x/y/index stable while valid is high and not yet granted.
// CONFIGURATION
//   FB_ARB_BOUNDS_CHECK_EN defined:
//   - granted request with x>=RESOLUTION_X or y>=RESOLUTION_Y is accepted (handshake completes, ptr advances).
//   - no write is issued for it: fb_wr_en=0 that cycle.
//   - drop_count increments by 1 per dropped request, saturates at 16'hFFFF, cleared only by reset.
//   FB_ARB_BOUNDS_CHECK_EN undefined:
//   - every request is written unmodified; drop_count tied to 0.
// TESTING
//   1 NUM_REQ=3, all valid held high 6 cycles -> grants 0,1,2,0,1,2; fb_wr_en high 6 consecutive cycles, data in grant order
//   2 Only req1 valid for 4 cycles (ptr=0) -> req1 granted 4 back-to-back cycles; fb_wr_en each following cycle; ptr ends at 2
//   3 RES 4x3, clear_start with clear_index=8'h2A -> 12 consecutive writes (0,0)..(3,2) of 2A starting 1 cycle later; clear_done with 12th; req_ready=0 throughout
//   4 clear_start pulsed again mid-clear plus req0 valid -> still 12 writes total, req0 granted in DONE cycle, single clear_done
//   5 resetn low after 5th clear write -> outputs 0 asynchronously, FSM IDLE, no clear_done, next clear restarts at (0,0)
//   6 BOUNDS_CHECK_EN, req0 x=RESOLUTION_X -> req_ready=1, fb_wr_en stays 0, drop_count 0->1; macro off -> write issued, drop_count=0

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// Requester-side handshake bundle for fb_write_arbiter: packed per-requester
// pixel writes with a valid/ready pair per requester.
interface fb_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XW      = 9,
    parameter int YW      = 9,
    parameter int IW      = 8
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*XW-1:0] req_x;
    logic [NUM_REQ*YW-1:0] req_y;
    logic [NUM_REQ*IW-1:0] req_index;

    modport master (
        output req_valid,
        output req_x,
        output req_y,
        output req_index,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_x,
        input  req_y,
        input  req_index,
        output req_ready
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port with a full-frame clear engine.
// Optional FB_ARB_BOUNDS_CHECK_EN drops out-of-range requests and counts them.
module fb_write_arbiter #(
    parameter int  RESOLUTION_X   = 400,
    parameter int  RESOLUTION_Y   = 300,
    parameter int  PALETTE_LENGTH = 256,
    parameter int  NUM_REQ        = 3,
    localparam int XW             = $clog2(RESOLUTION_X),
    localparam int YW             = $clog2(RESOLUTION_Y),
    localparam int IW             = $clog2(PALETTE_LENGTH)
) (
    input  logic              clk,
    input  logic              resetn,
    fb_write_arbiter_if.slave req,
    input  logic              clear_start,
    input  logic [IW-1:0]     clear_index,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [XW-1:0]     fb_wr_x,
    output logic [YW-1:0]     fb_wr_y,
    output logic [IW-1:0]     fb_wr_index,
    output logic              fb_wr_en,
    output logic [15:0]       drop_count
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [IW-1:0] fill_q, fill_d;
    logic          wr_en_q, wr_en_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;

    logic          grant_found;
    logic [PW-1:0] grant_idx;
    int            cand;
    logic          transfer;
    logic          in_range;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [IW-1:0] sel_idx;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!grant_found && req.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    assign transfer = grant_found && (state_q != ST_CLEAR);

    always_comb begin
        req.req_ready = '0;
        if (transfer) begin
            req.req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_x   = req.req_x[int'(grant_idx)*XW +: XW];
    assign sel_y   = req.req_y[int'(grant_idx)*YW +: YW];
    assign sel_idx = req.req_index[int'(grant_idx)*IW +: IW];

`ifdef FB_ARB_BOUNDS_CHECK_EN
    assign in_range = (int'(sel_x) < RESOLUTION_X) && (int'(sel_y) < RESOLUTION_Y);
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        fill_d   = fill_q;
        wr_en_d  = 1'b0;
        wr_x_d   = wr_x_q;
        wr_y_d   = wr_y_q;
        wr_idx_d = wr_idx_q;

        if (transfer) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    fill_d  = clear_index;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            ST_CLEAR: begin
                wr_en_d  = 1'b1;
                wr_x_d   = cx_q;
                wr_y_d   = cy_q;
                wr_idx_d = fill_q;
                if (cx_q == XW'(RESOLUTION_X - 1)) begin
                    cx_d = '0;
                    if (cy_q == YW'(RESOLUTION_Y - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Requester writes never overlap clear writes: transfer is gated off in CLEAR.
        if (transfer && in_range) begin
            wr_en_d  = 1'b1;
            wr_x_d   = sel_x;
            wr_y_d   = sel_y;
            wr_idx_d = sel_idx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            fill_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            fill_q   <= fill_d;
            wr_en_q  <= wr_en_d;
            wr_x_q   <= wr_x_d;
            wr_y_q   <= wr_y_d;
            wr_idx_q <= wr_idx_d;
        end
    end

`ifdef FB_ARB_BOUNDS_CHECK_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (transfer && !in_range && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'd0;
`endif

    assign clear_busy  = (state_q == ST_CLEAR);
    assign clear_done  = (state_q == ST_DONE);
    assign fb_wr_en    = wr_en_q;
    assign fb_wr_x     = wr_x_q;
    assign fb_wr_y     = wr_y_q;
    assign fb_wr_index = wr_idx_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter on a 4x3 frame with three requesters: grant tables,
// clear-engine sequences, async reset abort, out-of-range request, random traffic.
module tb_fb_write_arbiter;
    localparam int RX = 4;
    localparam int RY = 3;
    localparam int N  = 3;
    localparam int XW = 2;
    localparam int YW = 2;
    localparam int IW = 8;
`ifdef FB_ARB_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          clear_start = 1'b0;
    logic [IW-1:0] clear_index = '0;
    logic          clear_busy, clear_done, fb_wr_en;
    logic [XW-1:0] fb_wr_x;
    logic [YW-1:0] fb_wr_y;
    logic [IW-1:0] fb_wr_index;
    logic [15:0]   drop_count;

    fb_write_arbiter_if #(.NUM_REQ(N), .XW(XW), .YW(YW), .IW(IW)) rif ();

    fb_write_arbiter #(
        .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(256), .NUM_REQ(N)
    ) dut (
        .clk(clk), .resetn(resetn), .req(rif),
        .clear_start(clear_start), .clear_index(clear_index),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .fb_wr_x(fb_wr_x), .fb_wr_y(fb_wr_y), .fb_wr_index(fb_wr_index),
        .fb_wr_en(fb_wr_en), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending clear pixels are a queue; the frame is "clearing" while it is non-empty.
    typedef struct { int x; int y; } px_t;
    px_t    m_q[$];
    int     m_ptr, m_fill, m_x, m_y, m_i, m_drop;
    bit     m_en, m_done;
    int     wr_seen, done_seen;
    logic [N-1:0] last_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr = 0; m_fill = 0; m_x = 0; m_y = 0; m_i = 0; m_drop = 0;
        m_en = 0; m_done = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        int g, gx, gy, gi;
        bit clearing, start_ok;
        logic [N-1:0] er;
        px_t p;
        #1;
        clearing = (m_q.size() != 0);
        g = -1;
        if (!clearing) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && rif.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(rif.req_ready), 32'(er));
        check("clear_busy", 32'(clear_busy), 32'(clearing));
        check("clear_done", 32'(clear_done), 32'(m_done));
        last_ready = rif.req_ready;
        if (clear_done === 1'b1) done_seen++;

        if (clearing) begin
            p = m_q.pop_front();
            m_en = 1; m_x = p.x; m_y = p.y; m_i = m_fill;
            m_done = (m_q.size() == 0);
        end else begin
            start_ok = !m_done;
            m_done = 0;
            m_en = 0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                gx = int'(rif.req_x[g*XW +: XW]);
                gy = int'(rif.req_y[g*YW +: YW]);
                gi = int'(rif.req_index[g*IW +: IW]);
                if (BC && (gx >= RX || gy >= RY)) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_en = 1; m_x = gx; m_y = gy; m_i = gi;
                end
            end
            if (start_ok && clear_start) begin
                m_fill = int'(clear_index);
                for (int yy = 0; yy < RY; yy++)
                    for (int xx = 0; xx < RX; xx++) m_q.push_back('{xx, yy});
            end
        end

        @(posedge clk);
        #1;
        check("fb_wr_en", 32'(fb_wr_en), 32'(m_en));
        check("fb_wr_x", 32'(fb_wr_x), 32'(m_x));
        check("fb_wr_y", 32'(fb_wr_y), 32'(m_y));
        check("fb_wr_index", 32'(fb_wr_index), 32'(m_i));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        if (fb_wr_en === 1'b1) wr_seen++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rif.req_valid = '0;
        clear_start = 1'b0;
        resetn = 1'b0;
        #1;
        check("rst_wr_en", 32'(fb_wr_en), 32'd0);
        check("rst_wr_x", 32'(fb_wr_x), 32'd0);
        check("rst_wr_y", 32'(fb_wr_y), 32'd0);
        check("rst_wr_index", 32'(fb_wr_index), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_busy", 32'(clear_busy), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        check("rst_ready", 32'(rif.req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic set_req(input int i, input int x, input int y, input int idx);
        rif.req_x[i*XW +: XW]     = XW'(x);
        rif.req_y[i*YW +: YW]     = YW'(y);
        rif.req_index[i*IW +: IW] = IW'(idx);
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
    } vec_t;
    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base_w, base_d, d0;
        tbl[0] = '{3'b111, 3'b001}; tbl[1] = '{3'b111, 3'b010}; tbl[2]  = '{3'b111, 3'b100};
        tbl[3] = '{3'b111, 3'b001}; tbl[4] = '{3'b111, 3'b010}; tbl[5]  = '{3'b111, 3'b100};
        tbl[6] = '{3'b010, 3'b010}; tbl[7] = '{3'b010, 3'b010}; tbl[8]  = '{3'b010, 3'b010};
        tbl[9] = '{3'b010, 3'b010}; tbl[10] = '{3'b111, 3'b100};

        rif.req_valid = '0; rif.req_x = '0; rif.req_y = '0; rif.req_index = '0;
        last_ready = '0; wr_seen = 0; done_seen = 0;
        model_reset();
        #1;
        apply_reset();

        // Grant order tables: rotation with all valid, then a lone requester, then pointer check.
        for (int r = 0; r < 11; r++) begin
            for (int i = 0; i < N; i++) begin
                if (last_ready[i] || !rif.req_valid[i]) set_req(i, (r + i) % RX, i % RY, r * 16 + i);
            end
            rif.req_valid = tbl[r].valid;
            step();
            check("tbl_grant", 32'(last_ready), 32'(tbl[r].exp_ready));
        end
        rif.req_valid = '0;
        step();

        // Full clear with 2A.
        base_w = wr_seen; base_d = done_seen;
        clear_index = 8'h2A; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int c = 0; c < RX * RY + 1; c++) step();
        check("clear_writes", 32'(wr_seen - base_w), 32'(RX * RY));
        check("clear_done_cnt", 32'(done_seen - base_d), 32'd1);

        // Restart attempt mid-clear with req0 waiting.
        base_w = wr_seen; base_d = done_seen;
        clear_index = 8'h11; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int c = 0; c < 5; c++) step();
        set_req(0, 3, 1, 8'hC3);
        rif.req_valid = 3'b001; clear_start = 1'b1; clear_index = 8'h77;
        step();
        clear_start = 1'b0;
        for (int c = 0; c < RX * RY - 6; c++) step();
        check("midclr_writes", 32'(wr_seen - base_w), 32'(RX * RY));
        step();
        check("midclr_done_grant", 32'(last_ready), 32'b001);
        rif.req_valid = '0;
        step();
        check("midclr_done_cnt", 32'(done_seen - base_d), 32'd1);

        // Reset in the middle of a clear.
        base_w = wr_seen; base_d = done_seen;
        clear_index = 8'h3C; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int c = 0; c < 20 && (wr_seen - base_w) < 5; c++) step();
        check("abort_writes", 32'(wr_seen - base_w), 32'd5);
        apply_reset();
        for (int c = 0; c < 3; c++) step();
        check("abort_no_done", 32'(done_seen - base_d), 32'd0);
        clear_index = 8'h55; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        step();
        check("restart_x", 32'(fb_wr_x), 32'd0);
        check("restart_y", 32'(fb_wr_y), 32'd0);
        for (int c = 0; c < RX * RY; c++) step();

        // Out-of-range row.
        d0 = m_drop;
        set_req(0, 1, RY, 8'h99);
        rif.req_valid = 3'b001;
        step();
        check("oob_grant", 32'(last_ready), 32'b001);
        check("oob_wr_en", 32'(fb_wr_en), BC ? 32'd0 : 32'd1);
        check("oob_drop", 32'(drop_count), BC ? 32'(d0 + 1) : 32'd0);
        rif.req_valid = '0;
        step();

        // Random traffic honouring the hold-while-waiting rule.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_ready[i] || !rif.req_valid[i]) begin
                    rif.req_valid[i] = ($urandom_range(0, 9) < 6);
                    set_req(i, $urandom_range(0, RX - 1), $urandom_range(0, 3), $urandom_range(0, 255));
                end
            end
            clear_start = ($urandom_range(0, 39) == 0);
            clear_index = IW'($urandom_range(0, 255));
            step();
        end
        rif.req_valid = '0; clear_start = 1'b0;
        for (int c = 0; c < RX * RY + 3; c++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
